// File: rtl/cic_pkg.sv
// Shared constants and helpers for the 1-bit PDM to PCM CIC decimator.
// Accumulator width grows by log2(DEC_RATIO) bits per stage, plus one bit of input headroom.
package cic_pkg;
   localparam int ORDER_DEF     = 4;
   localparam int DEC_RATIO_DEF = 64;
   localparam int OUT_W_DEF     = 24;

   function automatic int acc_width(input int order, input int dec_ratio);
      return 1 + order * $clog2(dec_ratio);
   endfunction

   localparam int ACC_W_DEF = acc_width(ORDER_DEF, DEC_RATIO_DEF);

   typedef logic [ACC_W_DEF-1:0] acc_t;
endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: d_out = d_in - d_in(previous strobe); delay loads only when en is high.
// Latency: combinational difference, one-strobe delay register; no backpressure (free-running).
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int W = ACC_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] d_out
);
   logic [W-1:0] dly;

   // Modular subtraction: integrator wrap-around cancels out here.
   assign d_out = d_in - dly;

   always_ff @(posedge clk) begin
      if (rst)
         dly <= '0;
      else if (en)
         dly <= d_in;
   end
endmodule

// File: rtl/cic.sv
// PDM bitstream to saturated PCM decimator; out updates one clk after each dec_clk rising edge.
// No backpressure: output is held between strobes. Optional CIC_OUT_VALID_EN adds a one-cycle out_valid.
module cic
   import cic_pkg::*;
#(
   parameter int ORDER     = ORDER_DEF,
   parameter int DEC_RATIO = DEC_RATIO_DEF,
   parameter int OUT_W     = OUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dec_clk,
   input  logic             in,
   output logic [OUT_W-1:0] out
`ifdef CIC_OUT_VALID_EN
   ,
   output logic             out_valid
`endif
);
   localparam int ACC_W = acc_width(ORDER, DEC_RATIO);

   // dec_q resets high so a marker already high at reset release does not strobe.
   logic dec_q;
   logic strobe;

   assign strobe = dec_clk & ~dec_q;

   always_ff @(posedge clk) begin
      if (rst)
         dec_q <= 1'b1;
      else
         dec_q <= dec_clk;
   end

   logic [ACC_W-1:0] integ [ORDER];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++)
            integ[k] <= '0;
      end else begin
         integ[0] <= integ[0] + ACC_W'(in);
         for (int k = 1; k < ORDER; k++)
            integ[k] <= integ[k] + integ[k-1];
      end
   end

   logic [ACC_W-1:0] comb [ORDER+1];

   assign comb[0] = integ[ORDER-1];

   for (genvar g = 0; g < ORDER; g++) begin : g_comb
      cic_comb_stage #(.W(ACC_W)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .en    (strobe),
         .d_in  (comb[g]),
         .d_out (comb[g+1])
      );
   end

   // Full-scale input gives exactly 2^OUT_W, one past the top code.
   logic [OUT_W-1:0] sat_val;

   if (ACC_W > OUT_W) begin : g_sat
      assign sat_val = (|comb[ORDER][ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : comb[ORDER][OUT_W-1:0];
   end else begin : g_nosat
      assign sat_val = OUT_W'(comb[ORDER]);
   end

   always_ff @(posedge clk) begin
      if (rst)
         out <= '0;
      else if (strobe)
         out <= sat_val;
   end

`ifdef CIC_OUT_VALID_EN
   always_ff @(posedge clk) begin
      if (rst)
         out_valid <= 1'b0;
      else
         out_valid <= strobe;
   end
`endif
endmodule

// File: tb/tb_cic.sv
// Scoreboarded bench for cic: stimulus pushes expected outputs, a monitor pops on every marker edge.
module tb_cic;
   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic        dec_clk = 1'b0;
   logic        in      = 1'b0;
   logic [23:0] out;
`ifdef CIC_OUT_VALID_EN
   logic        out_valid;
`endif

   int checks = 0;
   int errors = 0;

   always #31.25ns clk = ~clk;

   cic dut (
      .clk     (clk),
      .rst     (rst),
      .dec_clk (dec_clk),
      .in      (in),
      .out     (out)
`ifdef CIC_OUT_VALID_EN
      ,
      .out_valid (out_valid)
`endif
   );

   logic [23:0] exp_q [$];

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic mon_dq  = 1'b1;
   logic mon_stb = 1'b0;
   logic mon_rst = 1'b0;
   bit   armed   = 1'b0;
   logic [23:0] last_exp = '0;

   always @(posedge clk) begin
      mon_stb <= dec_clk & ~mon_dq & ~rst;
      mon_dq  <= rst | dec_clk;
      mon_rst <= rst;
   end

   always @(negedge clk) begin
      logic [23:0] e;
      if (mon_rst) begin
         armed = 1'b1;
         last_exp = '0;
         chk("reset_out", out, 24'h0);
      end else if (armed) begin
         if (mon_stb) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL update_without_expectation: out=%h", out);
            end else begin
               e = exp_q.pop_front();
               chk("update", out, e);
               last_exp = e;
            end
         end else begin
            chk("hold", out, last_exp);
         end
      end
`ifdef CIC_OUT_VALID_EN
      if (armed)
         chk("out_valid", {23'd0, out_valid}, {23'd0, mon_stb});
`endif
   end

   // ---------------- stimulus + reference model ----------------
   logic [24:0] mi [4];
   logic [24:0] md [4];
   logic        mdq = 1'b1;

   int ph = 0, pc = 0, pstb = 0, dmode = 0, pat = 0, hand_from = 0;
   logic [23:0] hand_val = '0;

   function automatic logic [23:0] sat24(input logic [24:0] v);
      return v[24] ? 24'hFFFFFF : v[23:0];
   endfunction

   task automatic tick(input logic r);
      logic b, d, stb;
      logic [24:0] c, x;
      @(negedge clk);
      case (pat)
         0:       b = 1'b0;
         1:       b = 1'b1;
         2:       b = (pc % 2 == 0);
         3:       b = (pc % 4 == 0);
         default: b = 1'($urandom_range(0, 1));
      endcase
      case (dmode)
         0:       d = 1'b0;
         1:       d = (ph % 64 >= 32);
         default: d = 1'b1;
      endcase
      in = b;
      dec_clk = d;
      rst = r;
      if (r) begin
         for (int k = 0; k < 4; k++) begin
            mi[k] = '0;
            md[k] = '0;
         end
         mdq = 1'b1;
      end else begin
         stb = d & ~mdq;
         if (stb) begin
            c = mi[3];
            for (int k = 0; k < 4; k++) begin
               x = c;
               c = x - md[k];
               md[k] = x;
            end
            pstb++;
            if (hand_from != 0 && pstb >= hand_from)
               exp_q.push_back(hand_val);
            else
               exp_q.push_back(sat24(c));
         end
         for (int k = 3; k > 0; k--)
            mi[k] = mi[k] + mi[k-1];
         mi[0] = mi[0] + {24'd0, b};
         mdq = d;
      end
      ph++;
      pc++;
   endtask

   // hf = strobe index (within the phase) from which the hand value is expected; 0 = model only
   task automatic run(input int p, input int n, input int hf, input logic [23:0] hv);
      pat = p;
      hand_from = hf;
      hand_val = hv;
      pstb = 0;
      pc = 0;
      while (pstb < n)
         tick(1'b0);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         mi[k] = '0;
         md[k] = '0;
      end
      dmode = 0;
      pat = 0;
      repeat (10) tick(1'b0);
      tick(1'b1);
      dmode = 1;

      run(0, 10, 1, 24'h000000);          // silence: zero on every update
      run(1, 8, 6, 24'hFFFFFF);           // full scale ramps then saturates

      // reset exactly on a marker rising edge, with in=1
      pat = 1;
      while (ph % 64 != 32)
         tick(1'b0);
      tick(1'b1);
      run(1, 7, 6, 24'hFFFFFF);

      run(2, 8, 6, 24'h800000);           // 50% density
      run(3, 8, 6, 24'h400000);           // 25% density

      // marker stuck high: no updates, integrators keep running
      pat = 4;
      dmode = 2;
      repeat (300) tick(1'b0);
      dmode = 1;
      run(4, 6, 0, 24'h0);

      run(4, 300, 0, 24'h0);              // random bitstream vs model

      repeat (4) tick(1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: left=%0d required=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
